serial_deser: RTL
=================

# serial_deser

Parametrised serial-to-parallel deserializer that loads operand words for the FP adder datapath from a narrow serial link. It generalises the 32-bit single-lane loader to any WIDTH, LANES bits per beat and selectable bit order. It adds a double-buffered output with a valid/ready handshake, a frame-abort input and a sticky overrun flag. It sits between the external serial pins and the operand registers of the adder core.

## Interface
- WIDTH, 32: output word width in bits; must be a multiple of LANES.
- LANES, 1: serial bits accepted per write beat (1, 2, 4 or 8).
- MSB_FIRST, 0: 0 = first beat lands in bits [LANES-1:0]; 1 = first beat lands in the top LANES bits.

- clk_in  in  1  single clock, rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- serial_in  in  LANES  serial data for the current beat.
- wr_in  in  1  beat strobe; accepted only when input_rdy is 1.
- abort_in  in  1  synchronous discard of the partially filled frame.
- input_rdy  out  1  1 = the shifter accepts beats.
- parallel_out  out  WIDTH  assembled word, held stable while out_valid is 1.
- out_valid  out  1  parallel_out holds an unconsumed word.
- out_ready_in  in  1  consumer accepts the word; the transfer occurs when out_valid and out_ready_in are both 1.
- overrun_out  out  1  sticky flag: a beat was dropped.
- clr_ovr_in  in  1  synchronous clear of overrun_out.

## Operation
- BEATS = WIDTH/LANES. The beat counter is $clog2(BEATS) bits wide (minimum 1) and counts 0..BEATS-1.
- Shifter, LSB-first mode: new lanes enter at [WIDTH-1:WIDTH-LANES] and the register shifts right by LANES.
- Shifter, MSB-first mode: new lanes enter at [LANES-1:0] and the register shifts left by LANES.
- FSM has two states:
  - FILL (reset state). input_rdy = 1. Each wr_in shifts the data in and increments the counter. On the last beat (count = BEATS-1) the counter wraps to 0 and the completed word goes to the output stage.
    - If the output stage is free (out_valid = 0, or a transfer happens this cycle), the word loads into parallel_out and out_valid = 1. The state stays FILL.
    - Otherwise the word stays in the shifter and the state moves to HOLD.
  - HOLD. input_rdy = 0. On a transfer, the shifter word loads into parallel_out, out_valid stays 1, and the state returns to FILL.
- A transfer with no replacement word clears out_valid.
- wr_in while input_rdy = 0: the beat is dropped and overrun_out is set. The shifter and counter are unchanged.
- abort_in in FILL: the counter clears to 0 and the partial data is discarded. parallel_out, out_valid and overrun_out are unaffected.
- abort_in in HOLD: ignored, because the word is complete.
- abort_in together with wr_in: abort wins and the beat is discarded without setting overrun.
- clr_ovr_in together with a dropped beat: the set wins, so overrun_out = 1.
- Reset values: input_rdy 1, parallel_out 0, out_valid 0, overrun_out 0, counter 0, shifter 0, state FILL.
- Reset mid-frame: partial data is lost and no word is emitted.

## Timing
- Last-beat edge to out_valid = 1: 1 cycle, registered.
- Full frame with no backpressure: BEATS accepted beats, and back-to-back frames need no idle cycles.
- HOLD exit: the transfer edge loads the new word, and input_rdy = 1 in the next cycle.
- A last beat arriving in the same cycle as a transfer loads directly, so the state does not enter HOLD.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package fp_io_pkg holds:
  - the state enum (FILL, HOLD);
  - the BEATS and counter-width derivation function;
  - the elaboration assertions (WIDTH % LANES == 0, LANES ≤ WIDTH).
- Sub-module deser_shift_core holds the shifter register, bit-order mux and beat counter, and produces a last_beat pulse. The FSM, output register and flags live in the top level.

## Test plan
- LANES=1, MSB_FIRST=0: shift 0x3F800000 LSB first, out_ready_in = 1 → parallel_out = 0x3F800000 and out_valid is high for 1 cycle, starting 1 cycle after beat 32.
- LANES=4, MSB_FIRST=1: nibbles 4,0,4,9,0,F,D,B → parallel_out = 0x40490FDB.
- out_ready_in = 0, frames 0x11111111 then 0x22222222:
  - input_rdy falls after frame 2 and the state enters HOLD.
  - One extra wr_in → overrun_out = 1.
  - Assert ready for 1 cycle → 0x22222222 appears, out_valid stays 1, input_rdy = 1.
- 10 beats, then abort_in, then full frame 0xC0000000 → only 0xC0000000 is output.
- Last beat of 0x3F800000 in the same cycle as a transfer of a pending word → no HOLD entry, input_rdy stays 1, new word on the next cycle.
- rst_n_in low at beat 17 → all outputs return to reset values asynchronously. A subsequent full frame 0xDEADBEEF is assembled correctly.

Source files
------------

// File: rtl/serial_deser_pkg.sv
// -----------------------------------------------------------------------------
// fp_io_pkg
// Shared definitions for the serial operand loader of the FP adder datapath:
//   - deser_state_e : loader FSM states (FILL accepts beats, HOLD parks a
//                     completed word while the output register is occupied)
//   - beats_of      : beats per word (WIDTH / LANES)
//   - cnt_w_of      : beat counter width, never below 1 bit
//   - params_ok     : legality check on WIDTH / LANES used at elaboration
// -----------------------------------------------------------------------------
package fp_io_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } deser_state_e;

  function automatic int beats_of(input int width, input int lanes);
    return width / lanes;
  endfunction

  function automatic int cnt_w_of(input int width, input int lanes);
    int beats;
    beats = width / lanes;
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

  function automatic bit params_ok(input int width, input int lanes);
    bit lanes_legal;
    lanes_legal = (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8);
    return lanes_legal && (lanes <= width) && ((width % lanes) == 0);
  endfunction

endpackage

// File: rtl/serial_deser_if.sv
// -----------------------------------------------------------------------------
// serial_deser_if
// Bundles the serial-side beat inputs and the parallel-side valid/ready word
// output of the deserializer.
//   master : the link/consumer side (drives beats, abort, ready, overrun clear)
//   slave  : the deserializer itself
// Signals:
//   serial_in    [LANES]  beat data          wr_in        beat strobe
//   abort_in              drop partial frame input_rdy    shifter accepts beats
//   parallel_out [WIDTH]  assembled word     out_valid    word pending
//   out_ready_in          consumer accepts   overrun_out  sticky dropped-beat flag
//   clr_ovr_in            clear overrun_out
// -----------------------------------------------------------------------------
interface serial_deser_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 1
);

  logic [LANES-1:0] serial_in;
  logic             wr_in;
  logic             abort_in;
  logic             input_rdy;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             out_ready_in;
  logic             overrun_out;
  logic             clr_ovr_in;

  modport master (
    output serial_in, wr_in, abort_in, out_ready_in, clr_ovr_in,
    input  input_rdy, parallel_out, out_valid, overrun_out
  );

  modport slave (
    input  serial_in, wr_in, abort_in, out_ready_in, clr_ovr_in,
    output input_rdy, parallel_out, out_valid, overrun_out
  );

endinterface

// File: rtl/serial_deser_shift_core.sv
// -----------------------------------------------------------------------------
// deser_shift_core
// Shift register, bit-order selection and beat counter of the deserializer.
// Ports:
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   shift_en_i         accept serial_i this cycle
//   clear_i            discard the partial frame (counter and shifter to 0)
//   serial_i [LANES]   beat data
//   word_next_o        shifter contents after this cycle's beat; valid as the
//                      completed word in the cycle last_beat_o is high
//   word_o             current shifter contents (the parked word while HOLD)
//   last_beat_o        the beat being accepted completes the word
// -----------------------------------------------------------------------------
module deser_shift_core
  import fp_io_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             shift_en_i,
  input  logic             clear_i,
  input  logic [LANES-1:0] serial_i,
  output logic [WIDTH-1:0] word_next_o,
  output logic [WIDTH-1:0] word_o,
  output logic             last_beat_o
);

  localparam int BEATS = beats_of(WIDTH, LANES);
  localparam int CNT_W = cnt_w_of(WIDTH, LANES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [WIDTH-1:0] shift_q, shift_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // LSB-first: beats enter at the top and drift down, so the first beat ends
  // in [LANES-1:0]. MSB-first: beats enter at the bottom and move up.
  generate
    if (BEATS == 1) begin : g_single
      assign shifted = serial_i;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted = {shift_q[WIDTH-LANES-1:0], serial_i};
    end else begin : g_lsb
      assign shifted = {serial_i, shift_q[WIDTH-1:LANES]};
    end
  endgenerate

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en_i) begin
      shift_d = shifted;
      cnt_d   = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last_beat_o = shift_en_i && !clear_i && (cnt_q == LAST_CNT);
  assign word_next_o = shifted;
  assign word_o      = shift_q;

endmodule

// File: rtl/serial_deser.sv
// -----------------------------------------------------------------------------
// serial_deser
// Serial-to-parallel operand loader for the FP adder. Collects LANES bits per
// beat into a WIDTH-bit word, then presents it on a registered valid/ready
// output. A completed word that cannot be handed over is parked in the
// shifter (HOLD) so the output register and shifter form a double buffer.
// Ports:
//   clk_in    rising-edge clock
//   rst_n_in  asynchronous active-low reset
//   bus       serial_deser_if.slave: serial_in, wr_in, abort_in, input_rdy,
//             parallel_out, out_valid, out_ready_in, overrun_out, clr_ovr_in
// All bus outputs come straight from registers.
// -----------------------------------------------------------------------------
module serial_deser
  import fp_io_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic           clk_in,
  input logic           rst_n_in,
  serial_deser_if.slave bus
);

  generate
    if (!params_ok(WIDTH, LANES)) begin : g_bad_params
      $error("serial_deser: LANES must be 1/2/4/8, <= WIDTH, and divide WIDTH");
    end
  endgenerate

  deser_state_e     state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             rdy_q, rdy_d;

  logic             in_fill;
  logic             transfer;
  logic             shift_en;
  logic             clear;
  logic             drop;
  logic             last_beat;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] word_held;

  assign in_fill  = (state_q == FILL);
  assign transfer = valid_q && bus.out_ready_in;
  // Abort beats a simultaneous write; in HOLD abort has no effect.
  assign shift_en = in_fill && bus.wr_in && !bus.abort_in;
  assign clear    = in_fill && bus.abort_in;
  assign drop     = !in_fill && bus.wr_in;

  deser_shift_core #(
    .WIDTH     (WIDTH),
    .LANES     (LANES),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .shift_en_i  (shift_en),
    .clear_i     (clear),
    .serial_i    (bus.serial_in),
    .word_next_o (word_next),
    .word_o      (word_held),
    .last_beat_o (last_beat)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    case (state_q)
      FILL: begin
        if (last_beat) begin
          // Output register is free if empty or being drained this edge.
          if (!valid_q || transfer) begin
            out_d   = word_next;
            valid_d = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end else if (transfer) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (transfer) begin
          out_d   = word_held;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // A dropped beat outranks a simultaneous clear.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (bus.clr_ovr_in) begin
      ovr_d = 1'b0;
    end
  end

  assign rdy_d = (state_d == FILL);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= FILL;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.input_rdy    = rdy_q;
  assign bus.parallel_out = out_q;
  assign bus.out_valid    = valid_q;
  assign bus.overrun_out  = ovr_q;

endmodule
